// File: rtl/gated_reg_bank.sv
// Bank of CH clocked, gated WIDTH-bit holding registers with per-channel set,
// bank clear, atomic snapshot, change pulses and saturating stability tracking.
module gated_reg_bank #(
  parameter int unsigned      WIDTH    = 3,
  parameter int unsigned      CH       = 4,
  parameter logic [WIDTH-1:0] SET_VAL  = {WIDTH{1'b1}},
  parameter int unsigned      STABLE_N = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sclr,
  input  logic [CH-1:0]       sset,
  input  logic [CH-1:0]       gate,
  input  logic [CH*WIDTH-1:0] data,
  input  logic                snap,
  output logic [CH*WIDTH-1:0] q,
  output logic [CH-1:0]       changed,
  output logic [CH-1:0]       stable,
  output logic [CH*WIDTH-1:0] snap_q,
  output logic                snap_vld
);

  localparam int unsigned DW = CH * WIDTH;
  localparam int unsigned CW = $clog2(STABLE_N + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_N);

  logic [DW-1:0] q_nxt;
  logic [CH-1:0] changed_nxt;
  logic [CH-1:0] stable_nxt;
  logic [CW-1:0] stab_cnt     [CH];
  logic [CW-1:0] stab_cnt_nxt [CH];

  // Per-channel load priority (clear > set > gate > hold) and stability tracking
  always_comb begin
    q_nxt       = q;
    changed_nxt = '0;
    stable_nxt  = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      stab_cnt_nxt[i] = stab_cnt[i];
    end
    for (int unsigned i = 0; i < CH; i++) begin
      if (sclr) begin
        q_nxt[i*WIDTH +: WIDTH] = '0;
      end else if (sset[i]) begin
        q_nxt[i*WIDTH +: WIDTH] = SET_VAL;
      end else if (gate[i]) begin
        q_nxt[i*WIDTH +: WIDTH] = data[i*WIDTH +: WIDTH];
      end
      changed_nxt[i] = (q_nxt[i*WIDTH +: WIDTH] != q[i*WIDTH +: WIDTH]);
      // A same-value reload or a no-op clear counts as "no change"
      if (changed_nxt[i]) begin
        stab_cnt_nxt[i] = '0;
      end else if (stab_cnt[i] != CNT_MAX) begin
        stab_cnt_nxt[i] = stab_cnt[i] + CW'(1);
      end
      stable_nxt[i] = (stab_cnt_nxt[i] == CNT_MAX);
    end
  end

  // State and output registers; snapshot samples q before this edge's write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q        <= '0;
      changed  <= '0;
      stable   <= '0;
      snap_q   <= '0;
      snap_vld <= 1'b0;
      for (int unsigned i = 0; i < CH; i++) begin
        stab_cnt[i] <= '0;
      end
    end else begin
      q        <= q_nxt;
      changed  <= changed_nxt;
      stable   <= stable_nxt;
      snap_vld <= snap;
      if (snap) begin
        snap_q <= q;
      end
      for (int unsigned i = 0; i < CH; i++) begin
        stab_cnt[i] <= stab_cnt_nxt[i];
      end
    end
  end

endmodule

// File: tb/tb_gated_reg_bank.sv
// Scoreboard bench for gated_reg_bank: directed hand-computed vectors plus a
// random soak against a behavioural model, checked by a decoupled monitor.
module tb_gated_reg_bank;

  localparam int unsigned WIDTH = 3;
  localparam int unsigned CH    = 4;
  localparam int unsigned DW    = CH * WIDTH;
  localparam int          SN    = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sclr = 1'b0;
  logic [CH-1:0] sset = '0;
  logic [CH-1:0] gate = '0;
  logic [DW-1:0] data = '0;
  logic          snap = 1'b0;
  logic [DW-1:0] q;
  logic [CH-1:0] changed;
  logic [CH-1:0] stable;
  logic [DW-1:0] snap_q;
  logic          snap_vld;

  gated_reg_bank #(.WIDTH(WIDTH), .CH(CH), .STABLE_N(SN)) dut (
    .clk(clk), .rst(rst), .sclr(sclr), .sset(sset), .gate(gate), .data(data),
    .snap(snap), .q(q), .changed(changed), .stable(stable), .snap_q(snap_q),
    .snap_vld(snap_vld)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] q;
    logic [CH-1:0] chg;
    logic [CH-1:0] stb;
    logic [DW-1:0] sq;
    logic          sv;
    bit            he;
    logic [DW-1:0] hq;
    logic [CH-1:0] hc;
    logic [CH-1:0] hs;
    logic [DW-1:0] hsq;
    logic          hsv;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  logic [DW-1:0] m_q;
  logic [CH-1:0] m_chg;
  logic [CH-1:0] m_stb;
  logic [DW-1:0] m_sq;
  logic          m_sv;
  int            m_cnt [CH];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q = '0; m_chg = '0; m_stb = '0; m_sq = '0; m_sv = 1'b0;
    for (int i = 0; i < CH; i++) m_cnt[i] = 0;
  endtask

  task automatic model_step(input logic c_sclr, input logic [CH-1:0] c_sset,
                            input logic [CH-1:0] c_gate, input logic [DW-1:0] c_data,
                            input logic c_snap);
    logic [DW-1:0] nq;
    logic [WIDTH-1:0] o, n;
    if (c_snap) m_sq = m_q;
    m_sv = c_snap;
    nq = m_q;
    for (int i = 0; i < CH; i++) begin
      o = m_q[i*WIDTH +: WIDTH];
      if (c_sclr)         n = '0;
      else if (c_sset[i]) n = '1;
      else if (c_gate[i]) n = c_data[i*WIDTH +: WIDTH];
      else                n = o;
      m_chg[i] = (n != o);
      if (m_chg[i])       m_cnt[i] = 0;
      else if (m_cnt[i] < SN) m_cnt[i]++;
      m_stb[i] = (m_cnt[i] == SN);
      nq[i*WIDTH +: WIDTH] = n;
    end
    m_q = nq;
  endtask

  // One clock of stimulus: rh holds reset across the edge, rp pulses it mid-cycle
  task automatic cyc(input logic rh, input logic rp, input logic c_sclr,
                     input logic [CH-1:0] c_sset, input logic [CH-1:0] c_gate,
                     input logic [DW-1:0] c_data, input logic c_snap, input bit he,
                     input logic [DW-1:0] hq, input logic [CH-1:0] hc,
                     input logic [CH-1:0] hs, input logic [DW-1:0] hsq, input logic hsv);
    exp_t e;
    @(negedge clk);
    if (rp && !rh) begin
      rst = 1'b1;
      #1;
      check("async_rst_q", 32'(q), 32'd0);
      check("async_rst_flags", {24'd0, changed, stable}, 32'd0);
      check("async_rst_snap", {19'd0, snap_vld, snap_q}, 32'd0);
      rst = 1'b0;
    end else begin
      rst = rh;
    end
    sclr = c_sclr; sset = c_sset; gate = c_gate; data = c_data; snap = c_snap;
    if (rh || rp) model_reset();
    if (!rh) model_step(c_sclr, c_sset, c_gate, c_data, c_snap);
    e.q = m_q; e.chg = m_chg; e.stb = m_stb; e.sq = m_sq; e.sv = m_sv;
    e.he = he; e.hq = hq; e.hc = hc; e.hs = hs; e.hsq = hsq; e.hsv = hsv;
    sb.push_back(e);
  endtask

  task automatic dir(input logic c_sclr, input logic [CH-1:0] c_sset,
                     input logic [CH-1:0] c_gate, input logic [DW-1:0] c_data,
                     input logic c_snap, input logic [DW-1:0] hq, input logic [CH-1:0] hc,
                     input logic [CH-1:0] hs, input logic [DW-1:0] hsq, input logic hsv);
    cyc(1'b0, 1'b0, c_sclr, c_sset, c_gate, c_data, c_snap, 1'b1, hq, hc, hs, hsq, hsv);
  endtask

  // Monitor: outputs are presented every cycle; compare one item per edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("model_q", 32'(q), 32'(e.q));
        check("model_changed", 32'(changed), 32'(e.chg));
        check("model_stable", 32'(stable), 32'(e.stb));
        check("model_snap_q", 32'(snap_q), 32'(e.sq));
        check("model_snap_vld", 32'(snap_vld), 32'(e.sv));
        if (e.he) begin
          check("hand_q", 32'(q), 32'(e.hq));
          check("hand_changed", 32'(changed), 32'(e.hc));
          check("hand_stable", 32'(stable), 32'(e.hs));
          check("hand_snap_q", 32'(snap_q), 32'(e.hsq));
          check("hand_snap_vld", 32'(snap_vld), 32'(e.hsv));
        end
      end
    end
  end

  initial begin
    logic          r_sclr, r_snap, r_rp;
    logic [CH-1:0] r_sset, r_gate;
    logic [DW-1:0] r_data;
    model_reset();

    // Reset held while inputs toggle
    cyc(1'b1, 1'b0, 1'b0, 4'h0, 4'hF, 12'hABC, 1'b0, 1'b1, 12'h000, 4'h0, 4'h0, 12'h000, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 4'hF, 4'hF, 12'h123, 1'b1, 1'b1, 12'h000, 4'h0, 4'h0, 12'h000, 1'b0);

    // Load channel 1 with 3'b110
    dir(1'b0, 4'h0, 4'b0010, 12'h030, 1'b0, 12'h030, 4'b0010, 4'h0, 12'h000, 1'b0);
    dir(1'b0, 4'h0, 4'h0,    12'hFFF, 1'b0, 12'h030, 4'b0000, 4'h0, 12'h000, 1'b0);

    // Clear beats set and gate; then set beats gate
    dir(1'b1, 4'hF, 4'hF,    12'hFFF, 1'b0, 12'h000, 4'b0010, 4'h0, 12'h000, 1'b0);
    dir(1'b0, 4'h1, 4'h1,    12'h005, 1'b0, 12'h007, 4'b0001, 4'h0, 12'h000, 1'b0);

    // Stability: ch2/3 counting since reset, ch1 since clear, ch0 since set
    dir(1'b0, 4'h0, 4'h0, 12'h000, 1'b0, 12'h007, 4'h0, 4'b0000, 12'h000, 1'b0);
    dir(1'b0, 4'h0, 4'h0, 12'h000, 1'b0, 12'h007, 4'h0, 4'b0000, 12'h000, 1'b0);
    dir(1'b0, 4'h0, 4'h0, 12'h000, 1'b0, 12'h007, 4'h0, 4'b0000, 12'h000, 1'b0);
    dir(1'b0, 4'h0, 4'h0, 12'h000, 1'b0, 12'h007, 4'h0, 4'b1100, 12'h000, 1'b0);
    dir(1'b0, 4'h0, 4'h0, 12'h000, 1'b0, 12'h007, 4'h0, 4'b1100, 12'h000, 1'b0);
    dir(1'b0, 4'h0, 4'h0, 12'h000, 1'b0, 12'h007, 4'h0, 4'b1100, 12'h000, 1'b0);
    dir(1'b0, 4'h0, 4'h0, 12'h000, 1'b0, 12'h007, 4'h0, 4'b1110, 12'h000, 1'b0);
    dir(1'b0, 4'h0, 4'h0, 12'h000, 1'b0, 12'h007, 4'h0, 4'b1111, 12'h000, 1'b0);
    // Same-value reload keeps stable; a new value drops it and pulses changed
    dir(1'b0, 4'h0, 4'h1, 12'h007, 1'b0, 12'h007, 4'b0000, 4'b1111, 12'h000, 1'b0);
    dir(1'b0, 4'h0, 4'h1, 12'h003, 1'b0, 12'h003, 4'b0001, 4'b1110, 12'h000, 1'b0);

    // Snapshot returns pre-write values
    dir(1'b0, 4'h0, 4'hF, 12'h5A5, 1'b0, 12'h5A5, 4'b1111, 4'b0000, 12'h000, 1'b0);
    dir(1'b0, 4'h0, 4'hF, 12'hFFF, 1'b1, 12'hFFF, 4'b1111, 4'b0000, 12'h5A5, 1'b1);
    dir(1'b0, 4'h0, 4'h0, 12'h000, 1'b0, 12'hFFF, 4'b0000, 4'b0000, 12'h5A5, 1'b0);
    dir(1'b0, 4'h0, 4'h1, 12'h000, 1'b1, 12'hFF8, 4'b0001, 4'b0000, 12'hFFF, 1'b1);
    dir(1'b0, 4'h0, 4'h0, 12'h000, 1'b1, 12'hFF8, 4'b0000, 4'b0000, 12'hFF8, 1'b1);
    dir(1'b0, 4'h0, 4'h0, 12'h000, 1'b0, 12'hFF8, 4'b0000, 4'b0000, 12'hFF8, 1'b0);

    // Mid-cycle reset pulse, then first edge behaves as from reset
    cyc(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 12'h000, 1'b0, 1'b1, 12'h000, 4'h0, 4'h0, 12'h000, 1'b0);

    // Random soak against the model
    for (int n = 0; n < 1000; n++) begin
      r_sclr = ($urandom_range(0, 15) == 0);
      r_sset = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0;
      r_gate = 4'($urandom);
      r_data = 12'($urandom);
      r_snap = ($urandom_range(0, 3) == 0);
      r_rp   = ($urandom_range(0, 59) == 0);
      cyc(1'b0, r_rp, r_sclr, r_sset, r_gate, r_data, r_snap, 1'b0,
          12'h000, 4'h0, 4'h0, 12'h000, 1'b0);
    end

    @(negedge clk);
    sclr = 1'b0; sset = '0; gate = '0; snap = 1'b0;
    for (int k = 0; k < 8 && sb.size() != 0; k++) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
